// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: outcome evaluation, mispredict redirect,
// two-cycle front-end flush and a 2-bit saturating branch history table.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | normal operation, EX resolutions accepted
// FLUSH1 | first kill cycle after a redirect, EX inputs ignored
// FLUSH2 | second kill cycle after a redirect, EX inputs ignored
module branch_resolve #(
    parameter int BHT_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic [2:0]  ex_funct3,
    input  logic        BrEq,
    input  logic        BrLt,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred,
    input  logic [31:0] if_pc,
    input  logic        stall,
    output logic        BrUn,
    output logic        if_pred,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FLUSH1 = 2'd1;
    localparam logic [1:0] FLUSH2 = 2'd2;
    localparam int BHT_SIZE = 2 ** BHT_BITS;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [1:0]          bht [BHT_SIZE];
    logic [BHT_BITS-1:0] ex_idx;
    logic [BHT_BITS-1:0] if_idx;
    logic                lt;
    logic                taken;
    logic                resolve;
    logic                bht_update;
    logic                mispredict;
    logic [31:0]         target;
    logic [1:0]          bht_cur;
    logic [1:0]          bht_next;
    logic                unused_pc_bits;

    assign BrUn   = ex_funct3[1];
    assign lt     = BrLt & ~BrEq;
    assign ex_idx = ex_pc[BHT_BITS+1:2];
    assign if_idx = if_pc[BHT_BITS+1:2];

    // Upper fetch PC bits do not take part in the BHT lookup.
    assign unused_pc_bits = &{1'b0, if_pc[31:BHT_BITS+2], if_pc[1:0]};

    always_comb begin
        taken = 1'b0;
        case (ex_funct3)
            3'b000:          taken = BrEq;
            3'b001:          taken = ~BrEq;
            3'b100, 3'b110:  taken = lt;
            3'b101, 3'b111:  taken = ~lt;
            default:         taken = 1'b0;
        endcase
    end

    assign resolve    = ex_valid & ~stall & (state == IDLE) & (ex_branch | ex_jump);
    assign bht_update = resolve & ~ex_jump;

    always_comb begin
        mispredict = 1'b0;
        target     = ex_target;
        if (resolve) begin
            if (ex_jump) begin
                mispredict = 1'b1;
                target     = ex_target;
            end else begin
                mispredict = (taken != ex_pred);
                target     = taken ? ex_target : ex_pc + 32'd4;
            end
        end
    end

    always_comb begin
        bht_cur  = bht[ex_idx];
        bht_next = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = mispredict ? FLUSH1 : IDLE;
            FLUSH1:  state_next = FLUSH2;
            FLUSH2:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
            flush       <= 1'b0;
        end else begin
            state    <= state_next;
            redirect <= mispredict;
            flush    <= mispredict | (state == FLUSH1);
            if (mispredict) redirect_pc <= target;
        end
    end

    // Registered table read gives the pre-update value on a same-index write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
        end else if (bht_update) begin
            bht[ex_idx] <= bht_next;
        end
    end

    assign if_pred = bht[if_idx][1];

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter BHT_BITS, default 4; branch history table index width, 2**BHT_BITS entries.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ex_valid  input  1  EX-stage instruction is valid.
REQ-005 ex_branch  input  1  EX instruction is a conditional branch.
REQ-006 ex_jump  input  1  EX instruction is JAL/JALR.
REQ-007 ex_funct3  input  3  branch funct3 of the EX instruction.
REQ-008 BrEq  input  1  comparator equal flag for rs1 vs rs2.
REQ-009 BrLt  input  1  comparator less-than flag; don't-care when BrEq=1.
REQ-010 ex_pc  input  32  PC of the EX instruction.
REQ-011 ex_target  input  32  computed branch/jump target.
REQ-012 ex_pred  input  1  prediction carried with the EX instruction from fetch.
REQ-013 if_pc  input  32  current fetch PC.
REQ-014 stall  input  1  EX stage held; no resolution this cycle.
REQ-015 BrUn  output  1  unsigned-compare select to comparator, combinational.
REQ-016 if_pred  output  1  predicted-taken for if_pc, combinational.
REQ-017 redirect  output  1  registered PC redirect strobe.
REQ-018 redirect_pc  output  32  registered redirect address.
REQ-019 flush  output  1  registered kill for IF/ID and ID/EX contents.

Function
REQ-020 BrUn SHALL equal ex_funct3[1] (1 for BLTU/BGEU, 0 otherwise).
REQ-021 lt SHALL be BrLt & ~BrEq; BrLt is ignored whenever BrEq=1.
REQ-022 taken by funct3: 000 BrEq; 001 ~BrEq; 100/110 lt; 101/111 ~lt; 010/011 not taken.
REQ-023 A resolution occurs in cycle N when ex_valid=1, stall=0, state=IDLE, and ex_branch|ex_jump=1; if both flags are set, jump takes precedence.
REQ-024 Jump resolution SHALL always mispredict; target = ex_target.
REQ-025 Branch resolution mispredicts iff taken != ex_pred; target = taken ? ex_target : ex_pc+4 (mod 2**32).
REQ-026 On mispredict in cycle N: redirect=1 and redirect_pc=target in cycle N+1 only; flush=1 in cycles N+1 and N+2.
REQ-027 FSM states IDLE, FLUSH1, FLUSH2: IDLE->FLUSH1 on mispredict; FLUSH1->FLUSH2 and FLUSH2->IDLE unconditionally, stall notwithstanding.
REQ-028 In FLUSH1/FLUSH2, EX inputs SHALL be ignored: no redirect, no BHT update.
REQ-029 Correct prediction: no redirect, no flush, state stays IDLE.
REQ-030 redirect_pc SHALL hold its last value when redirect=0.
REQ-031 BHT: 2**BHT_BITS 2-bit saturating counters, index = pc[BHT_BITS+1:2].
REQ-032 Each branch resolution (not jump) SHALL update entry ex_pc index at the clock edge ending cycle N: +1 if taken (saturate at 11), -1 if not (saturate at 00).
REQ-033 if_pred = bit[1] of entry at if_pc index; same-cycle read/write to one index returns pre-update value.
REQ-034 stall=1 in IDLE: no update, no redirect, outputs and state unchanged.

Reset
REQ-035 rst=1 SHALL immediately force state=IDLE, redirect=0, flush=0, redirect_pc=0, all BHT entries=01.
REQ-036 rst asserted mid-flush SHALL abort the flush; first post-reset edge starts in IDLE.

Verification
REQ-037 Reset, if_pc=0x100 -> if_pred=0; BEQ BrEq=1 ex_pred=0 ex_pc=0x100 ex_target=0x200 -> redirect=1, redirect_pc=0x200 next cycle, flush 2 cycles, entry 0x100 becomes 10, if_pred=1.
REQ-038 BGE funct3=101, BrEq=1 BrLt=1, ex_pred=1 -> taken, no redirect, no flush; BGEU -> BrUn=1.
REQ-039 BNE not taken ex_pred=1 ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap).
REQ-040 Mispredict then valid mispredicting branch during FLUSH1 and FLUSH2 -> ignored: no second redirect, BHT unchanged.
REQ-041 Four taken resolutions at one index -> counter saturates at 11; four not-taken -> 00; funct3=010 -> not taken.
REQ-042 rst pulsed during FLUSH1 -> flush drops asynchronously, BHT all 01, stall=1 with mispredicting branch -> no action.
